// File: rtl/led_frame_writer.sv
// Wishbone initiator that streams RGB565 pixels into an LED matrix framebuffer
// as half-word writes and optionally commits the new base to the frame register.
module led_frame_writer #(
  parameter int ADDRESS_WIDTH = 30,
  parameter int DATA_WIDTH    = 32,
  parameter int REG_ADDRESS   = 0,
  parameter int N_COLS        = 20,
  parameter int N_ROWS        = 14,
  parameter int ROW_STRIDE    = 32,
  parameter int ACK_TIMEOUT   = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  output logic [ADDRESS_WIDTH-1:0]  adr_o,
  output logic [DATA_WIDTH-1:0]     dat_o,
  input  logic [DATA_WIDTH-1:0]     dat_i,
  output logic                      we_o,
  output logic [DATA_WIDTH/8-1:0]   sel_o,
  output logic                      stb_o,
  output logic                      cyc_o,
  input  logic                      ack_i,
  output logic [2:0]                cti_o,
  input  logic                      start,
  input  logic [13:0]               base_addr,
  input  logic                      commit,
  input  logic                      pix_valid,
  input  logic [15:0]               pix_data,
  input  logic                      pix_sof,
  output logic                      pix_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      err_sof,
  output logic                      err_timeout
);

  localparam int DATA_BYTES = DATA_WIDTH / 8;
  localparam int XW = $clog2(N_COLS);
  localparam int YW = $clog2(N_ROWS);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_PIX = 3'd1,
    WRITE    = 3'd2,
    COMMIT   = 3'd3,
    FINISH   = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [13:0]     r_base;
  logic            r_commit;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [15:0]     r_pix;
  logic [13:0]     r_h;
  logic [TW-1:0]   r_tmo;
  logic            r_err_sof;
  logic            r_err_timeout;

  logic [13:0]     w_h;
  logic            w_first;
  logic            w_last;
  logic            w_col_end;
  logic            w_tmo_last;
  logic            w_unused;

  assign w_h        = r_base + (14'(r_y) * 14'(ROW_STRIDE)) + 14'(r_x);
  assign w_first    = (r_x == '0) && (r_y == '0);
  assign w_col_end  = (r_x == XW'(N_COLS - 1));
  assign w_last     = w_col_end && (r_y == YW'(N_ROWS - 1));
  // An ack in the expiring cycle wins, so expiry is only checked without ack.
  assign w_tmo_last = (r_tmo <= TW'(1));
  assign w_unused   = ^dat_i;

  assign cti_o       = 3'b000;
  assign err_sof     = r_err_sof;
  assign err_timeout = r_err_timeout;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) w_next = WAIT_PIX;
        else       w_next = IDLE;
      end
      WAIT_PIX: begin
        if (pix_valid) w_next = WRITE;
        else           w_next = WAIT_PIX;
      end
      WRITE: begin
        if (ack_i) begin
          if (w_last) w_next = r_commit ? COMMIT : FINISH;
          else        w_next = WAIT_PIX;
        end else if (w_tmo_last) begin
          w_next = FINISH;
        end else begin
          w_next = WRITE;
        end
      end
      COMMIT: begin
        if (ack_i || w_tmo_last) w_next = FINISH;
        else                     w_next = COMMIT;
      end
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_base        <= 14'd0;
      r_commit      <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_pix         <= 16'd0;
      r_h           <= 14'd0;
      r_tmo         <= '0;
      r_err_sof     <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_base        <= base_addr;
            r_commit      <= commit;
            r_x           <= '0;
            r_y           <= '0;
            r_err_sof     <= 1'b0;
            r_err_timeout <= 1'b0;
          end
        end
        WAIT_PIX: begin
          if (pix_valid) begin
            r_pix <= pix_data;
            r_tmo <= TW'(ACK_TIMEOUT);
            // A stray start-of-frame resynchronises: this pixel becomes (0,0).
            if (pix_sof && !w_first) begin
              r_err_sof <= 1'b1;
              r_x       <= '0;
              r_y       <= '0;
              r_h       <= r_base;
            end else begin
              r_h <= w_h;
            end
          end
        end
        WRITE, COMMIT: begin
          if (ack_i) begin
            r_tmo <= TW'(ACK_TIMEOUT);
            if (r_state == WRITE) begin
              if (w_col_end) begin
                r_x <= '0;
                r_y <= w_last ? '0 : r_y + YW'(1);
              end else begin
                r_x <= r_x + XW'(1);
              end
            end
          end else if (w_tmo_last) begin
            r_err_timeout <= 1'b1;
          end else begin
            r_tmo <= r_tmo - TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    adr_o     = '0;
    dat_o     = '0;
    sel_o     = '0;
    we_o      = 1'b0;
    stb_o     = 1'b0;
    cyc_o     = 1'b0;
    pix_ready = (r_state == WAIT_PIX);
    busy      = (r_state != IDLE);
    done      = (r_state == FINISH);
    case (r_state)
      WRITE: begin
        cyc_o = 1'b1;
        stb_o = 1'b1;
        we_o  = 1'b1;
        adr_o = ADDRESS_WIDTH'(r_h[13:1]);
        sel_o = r_h[0] ? DATA_BYTES'(4'b1100) : DATA_BYTES'(4'b0011);
        dat_o = DATA_WIDTH'({r_pix, r_pix});
      end
      COMMIT: begin
        cyc_o = 1'b1;
        stb_o = 1'b1;
        we_o  = 1'b1;
        adr_o = ADDRESS_WIDTH'(REG_ADDRESS);
        sel_o = DATA_BYTES'(4'b0011);
        dat_o = DATA_WIDTH'({17'b0, r_base, 1'b0});
      end
      default: ;
    endcase
  end

endmodule
